lab2_proc_imem_resp_drop_queue: RTL and testbench



---
 rtl/lab2_proc_imem_resp_drop_queue.sv | 87 ++++++++
 tb/tb_lab2_proc_imem_resp_drop_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_imem_resp_drop_queue.sv
// Fetch response buffer: tracks outstanding imem requests, queues returning
// instruction words, and drops responses that belong to squashed fetches.
module lab2_proc_imem_resp_drop_queue #(
    parameter int unsigned p_num_entries  = 2,
    parameter int unsigned p_max_inflight = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  imem_req_fire,
    output logic                                  imem_req_ok,
    input  logic                                  squash,
    input  logic                                  mem_resp_val,
    output logic                                  mem_resp_rdy,
    input  logic [31:0]                           mem_resp_data,
    output logic                                  out_val,
    input  logic                                  out_rdy,
    output logic [31:0]                           out_data,
    output logic [$clog2(p_max_inflight+1)-1:0]   inflight
);

    localparam int unsigned CW = $clog2(p_max_inflight + 1);
    localparam int unsigned PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

    logic [31:0]   mem [p_num_entries];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] drop;

    logic resp_fire;
    logic enq;
    logic deq;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(p_num_entries - 1))
            return '0;
        else
            return ptr + PW'(1);
    endfunction

    always_comb begin
        mem_resp_rdy = reset && ((drop != '0) || (32'(count) < p_num_entries));
        out_val      = reset && (count != '0) && !squash;
        out_data     = mem[head];
        imem_req_ok  = reset && ((32'(inflight) + 32'(count)) < p_max_inflight);
        resp_fire    = mem_resp_val && mem_resp_rdy;
        // Any response accepted during a squash or while drops are pending is wrong-path.
        enq          = resp_fire && !squash && (drop == '0);
        deq          = out_val && out_rdy;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= inflight + CW'(imem_req_fire) - CW'(resp_fire);
            if (squash) begin
                // Requests outstanding before the redirect all become drops.
                drop  <= inflight - CW'(resp_fire);
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (resp_fire && (drop != '0))
                    drop <= drop - CW'(1);
                if (enq)
                    tail <= next_ptr(tail);
                if (deq)
                    head <= next_ptr(head);
                if (enq && !deq)
                    count <= count + CW'(1);
                else if (deq && !enq)
                    count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[tail] <= mem_resp_data;
    end

endmodule

// File: tb/tb_lab2_proc_imem_resp_drop_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of outstanding fetches and buffered words.
module tb_lab2_proc_imem_resp_drop_queue;

    localparam int NE = 2;
    localparam int MI = 2;
    localparam int CW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_fire;
    logic          imem_req_ok;
    logic          squash;
    logic          mem_resp_val;
    logic          mem_resp_rdy;
    logic [31:0]   mem_resp_data;
    logic          out_val;
    logic          out_rdy;
    logic [31:0]   out_data;
    logic [CW-1:0] inflight;

    always #5 clk = ~clk;

    lab2_proc_imem_resp_drop_queue #(
        .p_num_entries (NE),
        .p_max_inflight(MI)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req_fire(imem_req_fire),
        .imem_req_ok  (imem_req_ok),
        .squash       (squash),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_data(mem_resp_data),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .inflight     (inflight)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: one entry per outstanding request (1 = wrong-path), and buffered words.
    bit          pend[$];
    logic [31:0] mq[$];
    logic [31:0] got[$];

    logic          o_val, o_rdy, o_ok;
    logic [31:0]   o_data;
    logic [CW-1:0] o_infl;

    function automatic int n_wrong();
        int n = 0;
        foreach (pend[i]) if (pend[i]) n++;
        return n;
    endfunction

    function automatic bit m_rdy();
        return reset && (n_wrong() > 0 || mq.size() < NE);
    endfunction

    function automatic bit m_ok();
        return reset && (pend.size() + mq.size() < MI);
    endfunction

    // Drive one cycle, sample outputs before the edge, then advance the model.
    task automatic cycle(input logic f, input logic sq, input logic rv,
                         input logic [31:0] rd, input logic ordy);
        bit rf, dq, w;
        imem_req_fire = f;
        squash        = sq;
        mem_resp_val  = rv;
        mem_resp_data = rd;
        out_rdy       = ordy;
        #1;
        o_val  = out_val;
        o_data = out_data;
        o_rdy  = mem_resp_rdy;
        o_ok   = imem_req_ok;
        o_infl = inflight;
        rf = rv && m_rdy();
        dq = reset && mq.size() > 0 && !sq && ordy;
        @(posedge clk);
        if (o_val === 1'b1 && ordy) got.push_back(o_data);
        if (!reset) begin
            pend.delete();
            mq.delete();
        end else begin
            w = 1'b0;
            if (rf && pend.size() > 0) w = pend.pop_front();
            if (dq) void'(mq.pop_front());
            if (sq) begin
                mq.delete();
                foreach (pend[i]) pend[i] = 1'b1;
            end else if (rf && !w) begin
                mq.push_back(rd);
            end
            if (f) pend.push_back(1'b0);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(0, 0, 0, 32'h0, 0);
        reset = 1'b1;
        got.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(0, 0, 0, 32'h0, 0);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val: got %b want 0", o_val); end
        n_cmp++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_resp_rdy: got %b want 0", o_rdy); end
        n_cmp++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL reset_req_ok: got %b want 0", o_ok); end
        reset = 1'b1;
        got.delete();
        cycle(0, 0, 0, 32'h0, 0);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL release_out_val: got %b want 0", o_val); end
        n_cmp++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL release_resp_rdy: got %b want 1", o_rdy); end
        n_cmp++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL release_req_ok: got %b want 1", o_ok); end
        n_cmp++; if (o_infl !== CW'(0)) begin n_fail++; $display("FAIL release_inflight: got %0d want 0", o_infl); end
    endtask

    task automatic test_straight_line();
        logic [31:0] words [3] = '{32'h00000013, 32'h00100093, 32'h00200113};
        int nreq = 0;
        int nresp = 0;
        bit have_last = 1'b0;
        logic [31:0] last = '0;
        bit f, rv;
        logic [31:0] rd;
        do_reset();
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            f  = m_ok() && nreq < 3;
            rv = pend.size() > 0 && nresp < 3;
            rd = rv ? words[nresp] : 32'h0;
            cycle(f, 0, rv, rd, 1);
            if (have_last) begin
                n_cmp++;
                if (o_val !== 1'b1 || o_data !== last) begin
                    n_fail++;
                    $display("FAIL straight_latency: got val=%b data=%h want val=1 data=%h", o_val, o_data, last);
                end
            end
            n_cmp++; if (f && o_ok !== 1'b1) begin n_fail++; $display("FAIL straight_req_ok: got %b want 1", o_ok); end
            n_cmp++; if (o_infl > CW'(2)) begin n_fail++; $display("FAIL straight_inflight: got %0d want <=2", o_infl); end
            have_last = rv && o_rdy;
            if (have_last) begin last = rd; nresp++; end
            if (f) nreq++;
        end
        n_cmp++; if (got.size() != 3) begin n_fail++; $display("FAIL straight_count: got %0d words want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== words[i]) begin n_fail++; $display("FAIL straight_word%0d: got %h want %h", i, got[i], words[i]); end
        end
    endtask

    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 1, a, 0);
        cycle(0, 0, 1, b, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_two(32'h00500293, 32'h00600313);
        cycle(0, 0, 0, 32'h0, 0);
        n_cmp++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_full_rdy: got %b want 0", o_rdy); end
        n_cmp++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL bp_full_ok: got %b want 0", o_ok); end
        n_cmp++; if (o_infl !== CW'(0)) begin n_fail++; $display("FAIL bp_inflight: got %0d want 0", o_infl); end
        n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h00500293) begin n_fail++; $display("FAIL bp_head: got val=%b data=%h want 1 00500293", o_val, o_data); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL bp_ok_drain0: got %b want 0", o_ok); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL bp_ok_return: got %b want 1", o_ok); end
        n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h00600313) begin n_fail++; $display("FAIL bp_second: got val=%b data=%h want 1 00600313", o_val, o_data); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", o_val); end
        n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", got.size()); end
    endtask

    task automatic test_squash_inflight();
        do_reset();
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 1);
        cycle(0, 1, 0, 32'h0, 1);
        n_cmp++; if (o_infl !== CW'(2)) begin n_fail++; $display("FAIL sqi_inflight: got %0d want 2", o_infl); end
        n_cmp++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL sqi_ok: got %b want 0", o_ok); end
        cycle(0, 0, 1, 32'hDEADBEEF, 1);
        n_cmp++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL sqi_drop1_rdy: got %b want 1", o_rdy); end
        cycle(1, 0, 1, 32'hCAFEF00D, 1);
        n_cmp++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL sqi_drop2_rdy: got %b want 1", o_rdy); end
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqi_drop_val: got %b want 0", o_val); end
        cycle(0, 0, 1, 32'h00300193, 1);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqi_pre_val: got %b want 0", o_val); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h00300193) begin n_fail++; $display("FAIL sqi_target: got val=%b data=%h want 1 00300193", o_val, o_data); end
        n_cmp++; if (got.size() != 1) begin n_fail++; $display("FAIL sqi_delivered: got %0d words want 1", got.size()); end
    endtask

    task automatic test_squash_resp();
        do_reset();
        cycle(1, 0, 0, 32'h0, 1);
        cycle(0, 1, 1, 32'hBAD00BAD, 1);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqr_val: got %b want 0", o_val); end
        n_cmp++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL sqr_rdy: got %b want 1", o_rdy); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_infl !== CW'(0)) begin n_fail++; $display("FAIL sqr_inflight: got %0d want 0", o_infl); end
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqr_after_val: got %b want 0", o_val); end
        cycle(1, 0, 0, 32'h0, 1);
        cycle(0, 0, 1, 32'h00700393, 1);
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h00700393) begin n_fail++; $display("FAIL sqr_next: got val=%b data=%h want 1 00700393", o_val, o_data); end
        n_cmp++; if (got.size() != 1) begin n_fail++; $display("FAIL sqr_delivered: got %0d words want 1", got.size()); end
    endtask

    task automatic test_squash_buffered();
        do_reset();
        fill_two(32'h00800413, 32'h00900493);
        cycle(0, 1, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqb_same_val: got %b want 0", o_val); end
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b0) begin n_fail++; $display("FAIL sqb_next_val: got %b want 0", o_val); end
        n_cmp++; if (o_ok !== 1'b1 || o_rdy !== 1'b1) begin n_fail++; $display("FAIL sqb_empty: got ok=%b rdy=%b want 1 1", o_ok, o_rdy); end
        n_cmp++; if (got.size() != 0) begin n_fail++; $display("FAIL sqb_delivered: got %0d words want 0", got.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 1, 32'h00A00513, 0);
        reset = 1'b0;
        cycle(0, 0, 0, 32'h0, 0);
        n_cmp++; if (o_val !== 1'b0 || o_rdy !== 1'b0 || o_ok !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset: got val=%b rdy=%b ok=%b want 0 0 0", o_val, o_rdy, o_ok); end
        reset = 1'b1;
        got.delete();
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b0 || o_infl !== CW'(0)) begin n_fail++; $display("FAIL rmid_release: got val=%b infl=%0d want 0 0", o_val, o_infl); end
        n_cmp++; if (o_rdy !== 1'b1 || o_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_release_hs: got rdy=%b ok=%b want 1 1", o_rdy, o_ok); end
        cycle(1, 0, 0, 32'h0, 1);
        cycle(0, 0, 1, 32'h00400213, 1);
        cycle(0, 0, 0, 32'h0, 1);
        n_cmp++; if (o_val !== 1'b1 || o_data !== 32'h00400213) begin n_fail++; $display("FAIL rmid_enq: got val=%b data=%h want 1 00400213", o_val, o_data); end
    endtask

    task automatic test_random();
        bit f, sq, rv, ordy, e_val, e_rdy, e_ok;
        logic [31:0] rd, e_data;
        int e_infl;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom % 100) != 0;
            f    = m_ok() && ($urandom % 3) != 0;
            sq   = ($urandom % 10) == 0;
            rv   = pend.size() > 0 && ($urandom % 4) != 0;
            rd   = $urandom;
            ordy = ($urandom % 4) != 0;
            e_val  = reset && mq.size() > 0 && !sq;
            e_data = (mq.size() > 0) ? mq[0] : 32'h0;
            e_rdy  = m_rdy();
            e_ok   = m_ok();
            e_infl = reset ? pend.size() : 0;
            cycle(f, sq, rv, rd, ordy);
            n_cmp++; if (o_val !== e_val) begin n_fail++; $display("FAIL rnd_out_val c%0d: got %b want %b", c, o_val, e_val); end
            n_cmp++; if (o_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_resp_rdy c%0d: got %b want %b", c, o_rdy, e_rdy); end
            n_cmp++; if (o_ok !== e_ok) begin n_fail++; $display("FAIL rnd_req_ok c%0d: got %b want %b", c, o_ok, e_ok); end
            if (reset) begin
                n_cmp++; if (o_infl !== CW'(e_infl)) begin n_fail++; $display("FAIL rnd_inflight c%0d: got %0d want %0d", c, o_infl, e_infl); end
            end
            if (e_val) begin
                n_cmp++; if (o_data !== e_data) begin n_fail++; $display("FAIL rnd_out_data c%0d: got %h want %h", c, o_data, e_data); end
            end
            n_cmp++; if (f && o_ok !== 1'b1) begin n_fail++; $display("FAIL proto_req c%0d: req fired with ok=%b", c, o_ok); end
            n_cmp++; if (rv && o_rdy === 1'b1 && o_infl === CW'(0)) begin n_fail++; $display("FAIL proto_resp c%0d: response accepted with inflight=0", c); end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        imem_req_fire = 1'b0;
        squash        = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        out_rdy       = 1'b0;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_squash_inflight();
        test_squash_resp();
        test_squash_buffered();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
